uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter peripheral that responds to CPU data-bus writes decoded at the UART and status addresses. Bytes written to the UART address are queued in a small FIFO and serialized as 8N1 frames on `tx`. The status address returns FIFO and serializer state and clears a sticky overflow flag. The block sits beside the RAM interface and consumes its `uart`, `status`, `memwrite` and `memOut` outputs.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 88 ++++++++
 rtl/uart_tx_mmio.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART peripheral family: serializer state
// encoding, status-register bit positions and the default bit divisor.
// Nothing here is specific to the transmitter.
package uart_pkg;

  // Serializer states. IDLE is the only state that does not drive a frame.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } txState_e;

  // Bit positions inside the 16-bit status word.
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_IRQ   = 4;

  // Clock cycles per bit time when the instantiator does not override it.
  localparam int DEFAULT_CLK_DIV = 104;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always
// visible on dout_o, so a pop consumes the value shown in the same cycle.
// A push while full is only accepted when a pop happens on the same edge,
// which keeps a full FIFO streaming without losing a byte.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset, empties the FIFO
//   push_i   in   write din_i at the tail
//   pop_i    in   drop the head entry
//   din_i    in   WIDTH write data
//   dout_o   out  WIDTH head entry
//   full_o   out  count equals DEPTH
//   empty_o  out  count equals zero
//   count_o  out  number of stored entries, one bit wider than a pointer
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wrEn;
  logic             rdEn;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rdPtr_q];

  // Accept a write when there is room, or when the head is leaving on the
  // same edge. Pointers are exactly PTR_W bits, so they wrap on their own.
  always_comb begin
    wrEn    = push_i && (!full_o || pop_i);
    rdEn    = pop_i && !empty_o;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrEn) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (rdEn) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({wrEn, rdEn})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards any stored entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array. It needs no reset because an entry is only ever read
  // after it has been written.
  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      mem[wrPtr_q] <= din_i;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter. CPU writes to the data address are
// queued in a FIFO and shifted out LSB first; the status address reports
// FIFO and serializer state, and a write to it clears the sticky overflow.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-high reset
//   sel_uart    in   decode for the data register
//   sel_status  in   decode for the status register
//   memwrite    in   one-cycle bus write strobe
//   memIn       in   16-bit write data, bits [7:0] used for data writes
//   rdata       out  16-bit read data, combinational from registers
//   tx          out  serial line, idle high
//   irq         out  FIFO empty and serializer idle
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        sel_uart,
  input  logic        sel_status,
  input  logic        memwrite,
  input  logic [15:0] memIn,
  output logic [15:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  txState_e         state_q, state_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       lastByte_q, lastByte_d;

  logic             uartWr;
  logic             statusWr;
  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [7:0]       fifoDout;
  logic [CNT_W-1:0] fifoCount;
  logic             divDone;
  logic             busy;
  logic             unusedBits;

  assign uartWr     = memwrite & sel_uart;
  assign statusWr   = memwrite & sel_status;
  assign divDone    = (divCnt_q == DIV_W'(CLK_DIV - 1));
  assign busy       = (state_q != S_IDLE);
  assign irq        = fifoEmpty & ~busy;
  assign tx         = tx_q;
  assign unusedBits = ^{memIn[15:8], fifoCount};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (uartWr),
    .pop_i   (fifoPop),
    .din_i   (memIn[7:0]),
    .dout_o  (fifoDout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Serializer next-state logic. The divisor counter restarts on every
  // state entry, and STOP reloads straight into START when more data is
  // waiting so consecutive frames abut without an idle cycle. The line
  // level is computed from the next state so tx is a clean flop output.
  always_comb begin
    state_d  = state_q;
    divCnt_d = divCnt_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    fifoPop  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifoEmpty) begin
          fifoPop  = 1'b1;
          shift_d  = fifoDout;
          bitCnt_d = '0;
          divCnt_d = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (divDone) begin
          divCnt_d = '0;
          state_d  = S_DATA;
        end else begin
          divCnt_d = divCnt_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (divDone) begin
          divCnt_d = '0;
          shift_d  = {1'b0, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          divCnt_d = divCnt_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (divDone) begin
          divCnt_d = '0;
          if (!fifoEmpty) begin
            fifoPop  = 1'b1;
            shift_d  = fifoDout;
            bitCnt_d = '0;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          divCnt_d = divCnt_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Bus-side state: the sticky overflow flag and the last byte written.
  // An overflow on the same edge as a status clear leaves the flag set.
  always_comb begin
    ovf_d      = ovf_q;
    lastByte_d = lastByte_q;
    if (statusWr) begin
      ovf_d = 1'b0;
    end
    if (uartWr && fifoFull && !fifoPop) begin
      ovf_d = 1'b1;
    end
    if (uartWr) begin
      lastByte_d = memIn[7:0];
    end
  end

  // All peripheral registers. Reset forces the line high at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      divCnt_q   <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
      lastByte_q <= '0;
    end else begin
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
      lastByte_q <= lastByte_d;
    end
  end

  // Read mux. The status select wins if both decodes are active.
  always_comb begin
    rdata = '0;
    if (sel_status) begin
      rdata[ST_EMPTY] = fifoEmpty;
      rdata[ST_FULL]  = fifoFull;
      rdata[ST_BUSY]  = busy;
      rdata[ST_OVF]   = ovf_q;
      rdata[ST_IRQ]   = irq;
    end else if (sel_uart) begin
      rdata = {8'h00, lastByte_q};
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio
// Directed bench for uart_tx_mmio with a 4-cycle bit time and a 4-entry
// FIFO. Inputs change on the falling clock edge and outputs are sampled
// there too, well away from the rising edge where the DUT updates.
module tb_uart_tx_mmio;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        sel_uart;
  logic        sel_status;
  logic        memwrite;
  logic [15:0] memIn;
  logic [15:0] rdata;
  logic        tx;
  logic        irq;

  logic [7:0]  burst [8];
  logic [15:0] rd;
  int          checks = 0;
  int          errors = 0;

  uart_tx_mmio #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .sel_uart   (sel_uart),
    .sel_status (sel_status),
    .memwrite   (memwrite),
    .memIn      (memIn),
    .rdata      (rdata),
    .tx         (tx),
    .irq        (irq)
  );

  // 10 time-unit clock: rising edges at 5, 15, ...; falling at 10, 20, ...
  always #5 CLK = ~CLK;

  // One comparison: counted always, reported only when it does not match.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Writes burst[0..n-1] to the data address on consecutive cycles. The
  // upper data bits carry junk to show they are ignored.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      memwrite = 1'b1;
      sel_uart = 1'b1;
      memIn    = {8'hC3, burst[i]};
    end
    @(negedge CLK);
    memwrite = 1'b0;
    sel_uart = 1'b0;
    memIn    = '0;
  endtask

  // Single write to the status address, which clears the overflow flag.
  task automatic writeStatus();
    @(negedge CLK);
    memwrite   = 1'b1;
    sel_status = 1'b1;
    memIn      = 16'hFFFF;
    @(negedge CLK);
    memwrite   = 1'b0;
    sel_status = 1'b0;
    memIn      = '0;
  endtask

  // Combinational register read with one select raised for 1 time unit.
  task automatic readReg(input logic status, output logic [15:0] val);
    sel_status = status;
    sel_uart   = ~status;
    #1;
    val        = rdata;
    sel_status = 1'b0;
    sel_uart   = 1'b0;
  endtask

  // Checks one full 8N1 frame cycle by cycle, starting with the sample at
  // the current falling edge (first start-bit cycle) and finishing one
  // falling edge after the last stop-bit cycle.
  task automatic expectFrame(input logic [7:0] b, input string tag);
    int   bitIdx;
    logic expBit;
    for (int i = 0; i < 10*DIV; i++) begin
      bitIdx = i / DIV;
      if (bitIdx == 0)      expBit = 1'b0;
      else if (bitIdx == 9) expBit = 1'b1;
      else                  expBit = b[bitIdx-1];
      checkOutput($sformatf("%s_c%0d", tag, i), {15'b0, tx}, {15'b0, expBit});
      @(negedge CLK);
    end
  endtask

  // Raises reset between clock edges and checks that everything returns
  // to the idle, empty state without waiting for a clock.
  task automatic pulseReset(input string tag);
    #3;
    RST = 1'b1;
    #1;
    checkOutput({tag, "_tx"},    {15'b0, tx},  16'h0001);
    checkOutput({tag, "_irq"},   {15'b0, irq}, 16'h0001);
    checkOutput({tag, "_rdata"}, rdata,        16'h0000);
    readReg(1'b1, rd);
    checkOutput({tag, "_status"}, rd, 16'h0011);
    readReg(1'b0, rd);
    checkOutput({tag, "_data"}, rd, 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Directed sequence: reset, single frame, back-to-back frames, overflow
  // and clear, reset mid-frame, full FIFO push/pop collision, reset mid-DATA.
  initial begin
    RST        = 1'b1;
    sel_uart   = 1'b0;
    sel_status = 1'b0;
    memwrite   = 1'b0;
    memIn      = '0;

    // Power-on reset.
    #1;
    checkOutput("por_tx",    {15'b0, tx},  16'h0001);
    checkOutput("por_irq",   {15'b0, irq}, 16'h0001);
    checkOutput("por_rdata", rdata,        16'h0000);
    readReg(1'b1, rd);
    checkOutput("por_status", rd, 16'h0011);
    @(negedge CLK);
    RST = 1'b0;

    // Single frame of 0x55: line still high one edge after the write,
    // start bit after the next one, then 40 cycles of frame.
    burst[0] = 8'h55;
    applyStimulus(1);
    checkOutput("single_tx_pre", {15'b0, tx}, 16'h0001);
    readReg(1'b1, rd);
    checkOutput("single_status_queued", rd, 16'h0000);
    readReg(1'b0, rd);
    checkOutput("single_lastbyte", rd, 16'h0055);
    #1;
    checkOutput("single_nosel", rdata, 16'h0000);
    @(negedge CLK);
    checkOutput("single_irq_busy", {15'b0, irq}, 16'h0000);
    expectFrame(8'h55, "single");
    checkOutput("single_irq_done", {15'b0, irq}, 16'h0001);
    readReg(1'b1, rd);
    checkOutput("single_status_done", rd, 16'h0011);

    // Back-to-back writes give two abutting frames.
    burst[0] = 8'hA5;
    burst[1] = 8'h3C;
    applyStimulus(2);
    expectFrame(8'hA5, "b2b_A5");
    expectFrame(8'h3C, "b2b_3C");
    checkOutput("b2b_irq_done", {15'b0, irq}, 16'h0001);

    // Six writes into a 4-deep FIFO: one popped, four queued, one dropped.
    burst[0] = 8'h11;
    burst[1] = 8'h22;
    burst[2] = 8'h33;
    burst[3] = 8'h44;
    burst[4] = 8'h55;
    burst[5] = 8'h66;
    applyStimulus(6);
    readReg(1'b1, rd);
    checkOutput("ovf_status_set", rd, 16'h000E);
    writeStatus();
    readReg(1'b1, rd);
    checkOutput("ovf_status_clr", rd, 16'h0006);

    // Reset in the middle of that frame.
    pulseReset("rst_midframe");

    // Fill the FIFO behind a running frame, then push exactly on the
    // STOP-to-START pop edge: the push is accepted and nothing overflows.
    burst[0] = 8'h81;
    burst[1] = 8'h42;
    burst[2] = 8'h24;
    burst[3] = 8'h18;
    burst[4] = 8'hE7;
    applyStimulus(5);
    repeat (35) @(negedge CLK);
    readReg(1'b1, rd);
    checkOutput("coll_status_before", rd, 16'h0006);
    burst[0] = 8'h5A;
    applyStimulus(1);
    checkOutput("coll_tx_start", {15'b0, tx}, 16'h0000);
    readReg(1'b1, rd);
    checkOutput("coll_status_after", rd, 16'h0006);
    expectFrame(8'h42, "coll_42");
    expectFrame(8'h24, "coll_24");
    expectFrame(8'h18, "coll_18");
    expectFrame(8'hE7, "coll_E7");
    expectFrame(8'h5A, "coll_5A");
    checkOutput("coll_irq_done", {15'b0, irq}, 16'h0001);

    // Reset during data bit 3 of 0xF7 (bit 3 is 0) with three more queued.
    burst[0] = 8'hF7;
    burst[1] = 8'h01;
    burst[2] = 8'h02;
    burst[3] = 8'h03;
    applyStimulus(4);
    repeat (15) @(negedge CLK);
    checkOutput("rstdata_bit3", {15'b0, tx}, 16'h0000);
    pulseReset("rst_middata");
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("rstdata_quiet_%0d", i), {15'b0, tx}, 16'h0001);
    end
    checkOutput("rstdata_irq", {15'b0, irq}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
